// File: rtl/work_mng_types_pkg.sv
// Shared types, widths and parameter defaults for the work dispatcher.
package work_mng_types_pkg;

    localparam int NCORES_DEFAULT     = 3;
    localparam int DEPTH_DEFAULT      = 4;
    localparam int TEMP_LIMIT_DEFAULT = 75;

    localparam int ID_W    = 8;   // job identifier width
    localparam int TEMP_W  = 8;   // unsigned per-core temperature
    localparam int CORE_W  = 2;   // width of a core index
    localparam int TOTAL_W = 16;  // dispatched-job counter, wraps

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2
    } dispatch_state_t;

    typedef logic [ID_W-1:0]   job_id_t;
    typedef logic [TEMP_W-1:0] temp_t;

    // A core can take work when it is free and strictly cooler than the limit.
    function automatic logic core_eligible(input temp_t temp, input logic busy, input int limit);
        return !busy && (int'(temp) < limit);
    endfunction

endpackage

// File: rtl/work_dispatch_if.sv
// Job request, core status and dispatch signals of the work dispatcher.
interface work_dispatch_if
    import work_mng_types_pkg::*;
#(
    parameter int NCORES = NCORES_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // job request handshake
    logic                          job_valid;
    job_id_t                       job_id;
    logic                          job_ready;

    // core status
    logic [NCORES-1:0][TEMP_W-1:0] core_temp;
    logic [NCORES-1:0]             core_busy;

    // dispatch towards the cores
    logic [NCORES-1:0]             dispatch_valid;
    job_id_t                       dispatch_id;
    logic [CORE_W-1:0]             dispatch_core;
    logic [NCORES-1:0]             dispatch_ack;

    // status
    logic                          throttled;
    logic [CNT_W-1:0]              queue_count;
    logic [TOTAL_W-1:0]            dispatched_total;

    // Job source / core side.
    modport master (
        output job_valid, job_id, core_temp, core_busy, dispatch_ack,
        input  job_ready, dispatch_valid, dispatch_id, dispatch_core,
               throttled, queue_count, dispatched_total
    );

    // Dispatcher side.
    modport slave (
        input  job_valid, job_id, core_temp, core_busy, dispatch_ack,
        output job_ready, dispatch_valid, dispatch_id, dispatch_core,
               throttled, queue_count, dispatched_total
    );

endinterface

// File: rtl/job_fifo.sv
// Power-of-two job queue with occupancy count. A push presented while full is
// taken only on an edge where the head is popped, so the freed slot is reused.
module job_fifo
    import work_mng_types_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int W     = ID_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointer and occupancy values; pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Storage array.
    // NOTE: the data array has no reset; the pointers and count alone decide
    // which entries are valid, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointer and count registers with synchronous reset.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/work_dispatch.sv
// Thermal-aware job dispatcher: queues incoming jobs and issues the head job
// to the coolest free core, holding the issue until that core acknowledges.
module work_dispatch
    import work_mng_types_pkg::*;
#(
    parameter int NCORES     = NCORES_DEFAULT,
    parameter int DEPTH      = DEPTH_DEFAULT,
    parameter int TEMP_LIMIT = TEMP_LIMIT_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    work_dispatch_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    dispatch_state_t    state_q, state_d;
    logic [CORE_W-1:0]  sel_q, sel_d;
    logic [TOTAL_W-1:0] total_q, total_d;

    logic [NCORES-1:0]  eligible;
    logic               any_eligible;
    logic [CORE_W-1:0]  best_idx;
    temp_t              best_temp;

    logic               in_issue;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    job_id_t            head_id;
    logic [CNT_W-1:0]   count;

    assign in_issue = (state_q == ISSUE);
    // Only the acknowledge of the targeted core, and only while issuing, pops.
    assign pop      = in_issue && bus.dispatch_ack[sel_q];

    job_fifo #(
        .DEPTH (DEPTH),
        .W     (ID_W)
    ) u_job_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (bus.job_valid),
        .data_i  (bus.job_id),
        .pop_i   (pop),
        .data_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    // Pick the coolest eligible core; a strict compare keeps ties on the lowest index.
    // NOTE: combinational blocks use blocking assignments so later statements
    // see the running best value within the same evaluation.
    always_comb begin
        any_eligible = 1'b0;
        best_idx     = '0;
        best_temp    = '1;
        for (int i = 0; i < NCORES; i++) begin
            eligible[i] = core_eligible(bus.core_temp[i], bus.core_busy[i], TEMP_LIMIT);
            if (eligible[i] && (!any_eligible || bus.core_temp[i] < best_temp)) begin
                any_eligible = 1'b1;
                best_idx     = CORE_W'(i);
                best_temp    = bus.core_temp[i];
            end
        end
    end

    // Next-state logic: wait for work, wait for a cool core, then hold the issue.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = SELECT;
            end
            SELECT: begin
                if (any_eligible) begin
                    sel_d   = best_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The target is fixed until it acknowledges, whatever its temperature does.
                if (pop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        total_d = total_q + TOTAL_W'(pop);
    end

    // FSM, selected core and dispatch counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            sel_q   <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            total_q <= total_d;
        end
    end

    // Interface outputs; all handshake outputs are forced quiet while in reset.
    always_comb begin
        bus.job_ready        = 1'b1;
        bus.dispatch_valid   = '0;
        bus.dispatch_id      = '0;
        bus.dispatch_core    = '0;
        bus.throttled        = 1'b0;
        bus.queue_count      = count;
        bus.dispatched_total = total_q;
        if (!RST) begin
            bus.job_ready = !fifo_full;
            bus.throttled = !fifo_empty && !any_eligible;
            if (in_issue) begin
                bus.dispatch_valid = NCORES'(1) << sel_q;
                bus.dispatch_id    = head_id;
                bus.dispatch_core  = sel_q;
            end
        end
    end

    // At most one core is ever strobed.
    a_dispatch_onehot: assert property (@(posedge CLK) $onehot0(bus.dispatch_valid));

endmodule

// File: tb/tb_work_dispatch.sv
// Self-checking bench for work_dispatch: selection table, directed corner
// sequences and a randomized run compared against a queue-based reference model.
module tb_work_dispatch;
    import work_mng_types_pkg::*;

    localparam int NC  = 3;
    localparam int DP  = 4;
    localparam int LIM = 75;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    work_dispatch_if #(.NCORES(NC), .DEPTH(DP)) bus();

    work_dispatch #(
        .NCORES     (NC),
        .DEPTH      (DP),
        .TEMP_LIMIT (LIM)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: job list, a phase number and the chosen core.
    int unsigned mq[$];
    int          m_phase;   // 0 waiting for work, 1 choosing a core, 2 issued
    int          m_sel;
    int unsigned m_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Coolest free core under the limit, ties to the lowest index; -1 when none.
    function automatic int pick_core();
        int best_key = -1;
        for (int i = 0; i < NC; i++) begin
            if (bus.core_busy[i] == 1'b0 && int'(bus.core_temp[i]) < LIM) begin
                int key = int'(bus.core_temp[i]) * NC + i;
                if (best_key < 0 || key < best_key) best_key = key;
            end
        end
        return (best_key < 0) ? -1 : best_key % NC;
    endfunction

    task automatic compare_outputs();
        int pick;
        bit issuing;
        pick    = pick_core();
        issuing = !RST && (m_phase == 2);
        check("job_ready",        32'(bus.job_ready),        RST ? 32'd1 : 32'(mq.size() < DP));
        check("queue_count",      32'(bus.queue_count),      mq.size());
        check("dispatched_total", 32'(bus.dispatched_total), m_total);
        check("throttled",        32'(bus.throttled),        32'(!RST && mq.size() > 0 && pick < 0));
        check("dispatch_valid",   32'(bus.dispatch_valid),   issuing ? (32'd1 << m_sel) : 32'd0);
        check("dispatch_id",      32'(bus.dispatch_id),      issuing ? mq[0] : 32'd0);
        check("dispatch_core",    32'(bus.dispatch_core),    issuing ? 32'(m_sel) : 32'd0);
    endtask

    task automatic model_edge();
        bit pop;
        bit push;
        int pick;
        if (RST) begin
            mq.delete();
            m_phase = 0;
            m_sel   = 0;
            m_total = 0;
            return;
        end
        pop  = (m_phase == 2) && bus.dispatch_ack[m_sel];
        push = bus.job_valid && (mq.size() < DP || pop);
        pick = pick_core();
        case (m_phase)
            0: if (mq.size() > 0) m_phase = 1;
            1: if (pick >= 0) begin m_sel = pick; m_phase = 2; end
            2: if (pop) m_phase = 0;
            default: m_phase = 0;
        endcase
        if (pop) begin
            void'(mq.pop_front());
            m_total = (m_total + 1) & 32'hFFFF;
        end
        if (push) mq.push_back(int'(bus.job_id));
    endtask

    // One clock: compare against the model, advance it, then cross the edge.
    task automatic step();
        #1;
        compare_outputs();
        model_edge();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic set_temps(input int a, input int b, input int c);
        bus.core_temp[0] = 8'(a);
        bus.core_temp[1] = 8'(b);
        bus.core_temp[2] = 8'(c);
    endtask

    task automatic push_job(input int id);
        bus.job_valid = 1'b1;
        bus.job_id    = 8'(id);
        step();
        bus.job_valid = 1'b0;
    endtask

    task automatic wait_issue(input string name);
        int n = 0;
        while (bus.dispatch_valid == '0 && n < 10) begin
            step();
            n++;
        end
        check({name, "_issue_seen"}, 32'(bus.dispatch_valid != '0), 32'd1);
    endtask

    // Issue to core 1 is assumed by the callers (temps 40,30,50 all idle).
    task automatic ack_core1(input string name, input int exp_id);
        wait_issue(name);
        check({name, "_id"}, 32'(bus.dispatch_id), exp_id);
        bus.dispatch_ack = 3'b010;
        step();
        bus.dispatch_ack = 3'b000;
    endtask

    typedef struct {
        int         t0, t1, t2;
        logic [2:0] busy;
        int         exp_core;
    } sel_vec_t;

    sel_vec_t vecs[8];

    initial begin
        vecs[0] = '{40, 30, 50, 3'b000, 1};
        vecs[1] = '{30, 30, 60, 3'b000, 0};
        vecs[2] = '{74, 74, 74, 3'b000, 0};
        vecs[3] = '{10,  5,  5, 3'b000, 1};
        vecs[4] = '{10,  5,  5, 3'b010, 2};
        vecs[5] = '{74, 75, 80, 3'b000, 0};
        vecs[6] = '{20, 10,  0, 3'b100, 1};
        vecs[7] = '{76, 74, 90, 3'b000, 1};

        RST              = 1'b1;
        bus.job_valid    = 1'b0;
        bus.job_id       = '0;
        bus.core_temp    = '0;
        bus.core_busy    = '0;
        bus.dispatch_ack = '0;
        mq.delete();
        m_phase = 0;
        m_sel   = 0;
        m_total = 0;

        // First edge clears the design before anything is compared.
        @(negedge CLK);
        step();
        check("rst_job_ready",      32'(bus.job_ready),        32'd1);
        check("rst_dispatch_valid", 32'(bus.dispatch_valid),   32'd0);
        check("rst_queue_count",    32'(bus.queue_count),      32'd0);
        check("rst_total",          32'(bus.dispatched_total), 32'd0);
        check("rst_state",          32'(dut.state_q),          32'(IDLE));
        RST = 1'b0;
        step();

        // Selection table: single job from an empty queue, issue on the 2nd edge.
        for (int i = 0; i < 8; i++) begin
            set_temps(vecs[i].t0, vecs[i].t1, vecs[i].t2);
            bus.core_busy = vecs[i].busy;
            push_job(17 + i);
            check($sformatf("vec%0d_idle_valid", i), 32'(bus.dispatch_valid), 32'd0);
            step();
            check($sformatf("vec%0d_select_valid", i), 32'(bus.dispatch_valid), 32'd0);
            step();
            check($sformatf("vec%0d_valid", i), 32'(bus.dispatch_valid), 32'd1 << vecs[i].exp_core);
            check($sformatf("vec%0d_core", i),  32'(bus.dispatch_core),  vecs[i].exp_core);
            check($sformatf("vec%0d_id", i),    32'(bus.dispatch_id),    17 + i);
            bus.dispatch_ack = 3'(1 << vecs[i].exp_core);
            step();
            bus.dispatch_ack = 3'b000;
            check($sformatf("vec%0d_total", i), 32'(bus.dispatched_total), i + 1);
            check($sformatf("vec%0d_count", i), 32'(bus.queue_count),      32'd0);
        end
        bus.core_busy = '0;

        // All cores at or above the limit: throttle until core 2 cools to 74.
        set_temps(75, 80, 90);
        push_job(8'h22);
        step();
        check("thr_throttled", 32'(bus.throttled),      32'd1);
        check("thr_no_valid",  32'(bus.dispatch_valid), 32'd0);
        step();
        step();
        check("thr_still_throttled", 32'(bus.throttled),      32'd1);
        check("thr_still_no_valid",  32'(bus.dispatch_valid), 32'd0);
        bus.core_temp[2] = 8'd74;
        step();
        check("thr_valid", 32'(bus.dispatch_valid), 32'b100);
        check("thr_core",  32'(bus.dispatch_core),  32'd2);
        bus.dispatch_ack = 3'b100;
        step();
        bus.dispatch_ack = 3'b000;

        // Five back-to-back pushes with no acks: the fifth is dropped.
        set_temps(40, 30, 50);
        for (int k = 1; k <= 5; k++) begin
            bus.job_valid = 1'b1;
            bus.job_id    = 8'(k);
            step();
            if (k == 4) begin
                check("full_ready_low", 32'(bus.job_ready),   32'd0);
                check("full_count4",    32'(bus.queue_count), 32'd4);
            end
        end
        bus.job_valid = 1'b0;
        check("full_fifth_dropped", 32'(bus.queue_count), 32'd4);
        for (int k = 1; k <= 4; k++) ack_core1($sformatf("drain%0d", k), k);
        check("drain_empty", 32'(bus.queue_count), 32'd0);

        // Issue must hold through a hot target and a foreign ack.
        push_job(8'h37);
        wait_issue("hold");
        check("hold_valid0", 32'(bus.dispatch_valid), 32'b010);
        bus.core_temp[1] = 8'd99;
        bus.dispatch_ack = 3'b001;
        step();
        check("hold_valid1", 32'(bus.dispatch_valid), 32'b010);
        check("hold_id1",    32'(bus.dispatch_id),    32'h37);
        bus.dispatch_ack = 3'b000;
        step();
        check("hold_valid2", 32'(bus.dispatch_valid), 32'b010);
        check("hold_id2",    32'(bus.dispatch_id),    32'h37);
        bus.dispatch_ack = 3'b010;
        step();
        bus.dispatch_ack = 3'b000;
        check("hold_released", 32'(bus.dispatch_valid),   32'd0);
        check("hold_total",    32'(bus.dispatched_total), 32'd14);
        bus.core_temp[1] = 8'd30;

        // Push while full on the popping edge: count holds, new job goes last.
        for (int k = 0; k < 4; k++) push_job(8'h41 + k);
        wait_issue("fullpop");
        check("fullpop_ready", 32'(bus.job_ready), 32'd0);
        bus.job_valid    = 1'b1;
        bus.job_id       = 8'h45;
        bus.dispatch_ack = 3'b010;
        step();
        bus.job_valid    = 1'b0;
        bus.dispatch_ack = 3'b000;
        check("fullpop_count", 32'(bus.queue_count), 32'd4);
        for (int k = 0; k < 4; k++) ack_core1($sformatf("fullpop_drain%0d", k), 8'h42 + k);

        // Reset mid-issue discards everything; a late ack does nothing.
        for (int k = 0; k < 3; k++) push_job(8'h51 + k);
        wait_issue("rstmid");
        check("rstmid_count3", 32'(bus.queue_count), 32'd3);
        RST              = 1'b1;
        bus.dispatch_ack = 3'b010;
        step();
        check("rstmid_count0", 32'(bus.queue_count),    32'd0);
        check("rstmid_valid0", 32'(bus.dispatch_valid), 32'd0);
        check("rstmid_state",  32'(dut.state_q),        32'(IDLE));
        RST = 1'b0;
        step();
        bus.dispatch_ack = 3'b000;
        check("late_ack_total", 32'(bus.dispatched_total), 32'd0);
        check("late_ack_valid", 32'(bus.dispatch_valid),   32'd0);

        // Counter wrap: preload 0xFFFF, one more dispatch gives 0.
        force dut.total_q = 16'hFFFF;
        m_total = 32'hFFFF;
        step();
        release dut.total_q;
        check("wrap_preload", 32'(bus.dispatched_total), 32'hFFFF);
        push_job(8'h61);
        ack_core1("wrap", 8'h61);
        check("wrap_total", 32'(bus.dispatched_total), 32'd0);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            RST           = ($urandom_range(0, 149) == 0);
            bus.job_valid = 1'($urandom_range(0, 1));
            bus.job_id    = 8'($urandom);
            for (int i = 0; i < NC; i++) bus.core_temp[i] = 8'($urandom_range(60, 85));
            bus.core_busy    = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            bus.dispatch_ack = 3'($urandom);
            step();
        end
        RST              = 1'b0;
        bus.job_valid    = 1'b0;
        bus.dispatch_ack = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/work_dispatch.md
WORK_DISPATCH -- requirements
Module: work_dispatch

Interface
REQ-001 SHALL have parameter NCORES, default 3: number of cores served.
REQ-002 SHALL have parameter DEPTH, default 4: job queue entries (power of two).
REQ-003 SHALL have parameter TEMP_LIMIT, default 75: a core is eligible only when its temperature is strictly below this value.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset; synchronous, active-high.
REQ-006 SHALL have ports job_valid (input, 1 bit), job_id (input, 8 bits) and job_ready (output, 1 bit): the job request handshake.
REQ-007 SHALL have port core_temp, input, NCORES x 8 bits: unsigned per-core temperature.
REQ-008 SHALL have port core_busy, input, NCORES bits: the core is executing and is not eligible.
REQ-009 SHALL have port dispatch_valid, output, NCORES bits: one-hot issue strobe.
REQ-010 SHALL have ports dispatch_id (output, 8 bits) and dispatch_core (output, 2 bits): the issued job and the target core index.
REQ-011 SHALL have port dispatch_ack, input, NCORES bits: per-core acceptance.
REQ-012 SHALL have port throttled, output, 1 bit: the queue is non-empty and no core is eligible.
REQ-013 SHALL have ports queue_count (output, 3 bits) and dispatched_total (output, 16 bits): status outputs.

Function
REQ-014 SHALL accept a job on a rising edge where job_valid=1 and job_ready=1; job_ready SHALL equal (queue_count < DEPTH).
REQ-015 SHALL pop the queue head only on an edge in ISSUE where dispatch_ack[sel]=1.
REQ-016 SHALL, on a simultaneous push and pop, leave queue_count unchanged and keep jobs in FIFO order.
REQ-017 SHALL implement FSM states IDLE, SELECT and ISSUE.
REQ-018 SHALL move IDLE->SELECT when queue_count>0; otherwise it SHALL stay in IDLE.
REQ-019 SHALL evaluate eligibility in SELECT as core_busy[i]=0 and core_temp[i]<TEMP_LIMIT.
REQ-020 SHALL, in SELECT, latch sel = the eligible core with the lowest temperature (ties go to the lowest index) and move to ISSUE.
REQ-021 SHALL stay in SELECT with throttled=1 while no core is eligible, re-evaluating every cycle.
REQ-022 SHALL, in ISSUE, drive dispatch_valid[sel]=1, dispatch_id=head and dispatch_core=sel, and hold them stable until acked.
REQ-023 SHALL NOT withdraw or retarget an issue in ISSUE, even if the target's temperature rises above the limit.
REQ-024 SHALL move ISSUE->IDLE on ack and increment dispatched_total on each pop, wrapping from 0xFFFF to 0.
REQ-025 SHALL ignore dispatch_ack bits for cores other than sel, and all acks outside ISSUE.
REQ-026 SHALL drive dispatch_valid high on the 2nd edge after the accepting edge, given an empty queue, IDLE state and an eligible core.
REQ-027 SHALL keep dispatch_valid one-hot or zero at all times.
REQ-028 SHALL ignore job_valid when the queue is full, with no overwrite and no change in count.

Reset
REQ-029 SHALL, with RST=1 at an edge, set state=IDLE, queue_count=0, read/write pointers=0, sel=0 and dispatched_total=0.
REQ-030 SHALL hold dispatch_valid=0, dispatch_core=0, dispatch_id=0, throttled=0 and job_ready=1 while in reset.
REQ-031 SHALL discard all queued and in-flight jobs when RST is asserted mid-ISSUE; a late ack SHALL have no effect.

Structure
REQ-032 SHALL place the state enum (dispatch_state_t), TEMP_LIMIT default, NCORES and DEPTH defaults in work_mng_types_pkg.
REQ-033 SHALL implement the queue as sub-module job_fifo (push/pop/full/empty/count, 8-bit data); the FSM and selection SHALL be in work_dispatch.

Verification
REQ-034 SHALL verify: temps {40,30,50}, all idle, push id 0x11 -> dispatch_valid=3'b010, dispatch_core=1 on the 2nd edge; ack -> dispatched_total=1, queue_count=0.
REQ-035 SHALL verify: temps {30,30,60} -> core 0 selected (tie rule); temps {75,80,90} -> throttled=1, no dispatch_valid; drop core 2 to 74 -> core 2 selected next cycle.
REQ-036 SHALL verify: push 5 jobs back-to-back with no acks -> job_ready=0 after the 4th, 5th ignored; drain -> ids issued in order 1,2,3,4.
REQ-037 SHALL verify: in ISSUE to core 1, raise core_temp[1] to 99 and pulse dispatch_ack[0] -> dispatch_valid stays 3'b010, id unchanged until dispatch_ack[1].
REQ-038 SHALL verify: push while full and popping in the same cycle -> queue_count stays 4 and the new job is issued last.
REQ-039 SHALL verify: assert RST during ISSUE with 3 queued -> next cycle queue_count=0, dispatch_valid=0, state IDLE; preload dispatched_total=0xFFFF, ack one job -> 0x0000.
